// File: rtl/baud_gen_frac.sv
// Fractional UART baud generator: oversample, bit and bit-centre ticks from a
// fixed-point divisor, with run-time reload and phase resynchronisation.
module baud_gen_frac #(
    parameter int CLK_FREQ    = 100_000_000,
    parameter int BAUD_RATE   = 9600,
    parameter int OVERSAMPLE  = 16,
    parameter int DIV_W       = 12,
    parameter int FRAC_W      = 4,
    parameter int DEFAULT_DIV = int'((64'(CLK_FREQ) * (64'd1 << FRAC_W)
                                      + (64'(BAUD_RATE) * 64'(OVERSAMPLE)) / 64'd2)
                                     / (64'(BAUD_RATE) * 64'(OVERSAMPLE)))
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                en,
    input  logic                                                div_load,
    input  logic [DIV_W+FRAC_W-1:0]                             div_in,
    input  logic                                                resync,
    output logic                                                os_tick,
    output logic                                                baud_tick,
    output logic                                                mid_tick,
    output logic [((OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1)-1:0] os_phase,
    output logic [DIV_W+FRAC_W-1:0]                             div_cur
);

    localparam int DV_W  = DIV_W + FRAC_W;
    localparam int CNT_W = DIV_W + 1;
    localparam int PH_W  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [DV_W-1:0] DEF_DIV    = DV_W'(DEFAULT_DIV);
    localparam logic [PH_W-1:0] PH_LAST    = PH_W'(OVERSAMPLE - 1);
    localparam logic [PH_W-1:0] PH_MID     = PH_W'(OVERSAMPLE / 2);

    // Integer parts below 2 cannot produce a one-cycle-wide tick train.
    function automatic logic [DV_W-1:0] clamp_div(input logic [DV_W-1:0] d);
        logic [DV_W-1:0] r;
        r = d;
        if (d[DV_W-1:FRAC_W] < DIV_W'(2)) begin
            r[DV_W-1:FRAC_W] = DIV_W'(2);
        end else begin
            r = d;
        end
        return r;
    endfunction

    logic [DV_W-1:0]   div_q,   div_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [FRAC_W-1:0] acc_q,   acc_d;
    logic              ext_q,   ext_d;
    logic              first_q, first_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic              os_q,    os_d;
    logic              baud_q,  baud_d;
    logic              mid_q,   mid_d;

    logic [CNT_W-1:0]  div_int_s;
    logic [FRAC_W-1:0] div_frac_s;
    logic [CNT_W-1:0]  tgt_s;
    logic              fire_s;
    logic [FRAC_W:0]   acc_sum_s;
    logic [PH_W-1:0]   phase_nxt_s;

    // Interval target: the post-restart interval is one cycle shorter in count
    // terms because the restart cycle itself consumes the first slot.
    always_comb begin
        div_int_s   = {1'b0, div_q[DV_W-1:FRAC_W]};
        div_frac_s  = div_q[FRAC_W-1:0];
        acc_sum_s   = {1'b0, acc_q} + {1'b0, div_frac_s};
        if (first_q) begin
            tgt_s = div_int_s - CNT_W'(2);
        end else begin
            tgt_s = div_int_s - CNT_W'(1) + {{DIV_W{1'b0}}, ext_q};
        end
        fire_s = (cnt_q == tgt_s);
        if (phase_q == PH_LAST) begin
            phase_nxt_s = '0;
        end else begin
            phase_nxt_s = phase_q + PH_W'(1);
        end
    end

    // Next-state selection in priority order: load, resync, enabled count.
    always_comb begin
        div_d   = div_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ext_d   = ext_q;
        first_d = first_q;
        phase_d = phase_q;
        os_d    = 1'b0;
        baud_d  = 1'b0;
        mid_d   = 1'b0;
        if (div_load || resync) begin
            if (div_load) begin
                div_d = clamp_div(div_in);
            end else begin
                div_d = div_q;
            end
            cnt_d   = '0;
            acc_d   = '0;
            ext_d   = 1'b0;
            first_d = 1'b1;
            phase_d = '0;
        end else if (en) begin
            if (fire_s) begin
                cnt_d   = '0;
                acc_d   = acc_sum_s[FRAC_W-1:0];
                ext_d   = acc_sum_s[FRAC_W];
                first_d = 1'b0;
                phase_d = phase_nxt_s;
                os_d    = 1'b1;
                baud_d  = (phase_nxt_s == '0);
                mid_d   = (phase_nxt_s == PH_MID);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q   <= DEF_DIV;
            cnt_q   <= '0;
            acc_q   <= '0;
            ext_q   <= 1'b0;
            first_q <= 1'b1;
            phase_q <= '0;
            os_q    <= 1'b0;
            baud_q  <= 1'b0;
            mid_q   <= 1'b0;
        end else begin
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ext_q   <= ext_d;
            first_q <= first_d;
            phase_q <= phase_d;
            os_q    <= os_d;
            baud_q  <= baud_d;
            mid_q   <= mid_d;
        end
    end

    assign os_tick   = os_q;
    assign baud_tick = baud_q;
    assign mid_tick  = mid_q;
    assign os_phase  = phase_q;
    assign div_cur   = div_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed bench for baud_gen_frac: default, x16 instance plus an OVERSAMPLE=1
// instance sharing the same stimulus.
module tb_baud_gen_frac;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        div_load = 1'b0;
    logic [15:0] div_in = 16'h0000;
    logic        resync = 1'b0;

    logic        os_tick, baud_tick, mid_tick;
    logic [3:0]  os_phase;
    logic [15:0] div_cur;

    logic        os1_tick, baud1_tick, mid1_tick;
    logic [0:0]  os1_phase;
    logic [15:0] div1_cur;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int os1_count = 0;
    int os_t[$];
    int ph_t[$];
    int baud_t[$];
    int mid_t[$];

    baud_gen_frac dut (
        .clk(clk), .rst(rst), .en(en), .div_load(div_load), .div_in(div_in),
        .resync(resync), .os_tick(os_tick), .baud_tick(baud_tick),
        .mid_tick(mid_tick), .os_phase(os_phase), .div_cur(div_cur)
    );

    baud_gen_frac #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .OVERSAMPLE(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .div_load(div_load), .div_in(div_in),
        .resync(resync), .os_tick(os1_tick), .baud_tick(baud1_tick),
        .mid_tick(mid1_tick), .os_phase(os1_phase), .div_cur(div1_cur)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Tick recorder, sampled on the falling edge.
    always @(negedge clk) begin
        if (os_tick) begin
            os_t.push_back(cyc);
            ph_t.push_back(int'(os_phase));
        end
        if (baud_tick) baud_t.push_back(cyc);
        if (mid_tick) mid_t.push_back(cyc);
        if (os1_tick || baud1_tick || mid1_tick) begin
            check_eq("os1_baud", baud1_tick, os1_tick);
            check_eq("os1_mid", mid1_tick, os1_tick);
            check_eq("os1_phase", os1_phase, 0);
            os1_count++;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_q();
        os_t.delete();
        ph_t.delete();
        baud_t.delete();
        mid_t.delete();
    endtask

    task automatic wait_os(input int n, input int budget, input string tag);
        int k = 0;
        while (os_t.size() < n && k < budget) begin
            step();
            k++;
        end
        if (os_t.size() < n) check_eq(tag, os_t.size(), n);
    endtask

    // Pulse div_load for one cycle; returns the cycle of the restart edge.
    task automatic load_div(input logic [15:0] v, output int r);
        div_in = v;
        div_load = 1'b1;
        step();
        div_load = 1'b0;
        r = cyc;
        clear_q();
    endtask

    initial begin
        int r;
        int n_before;
        int t_gap;

        repeat (4) step();
        check_eq("rst_os", os_tick, 0);
        check_eq("rst_baud", baud_tick, 0);
        check_eq("rst_mid", mid_tick, 0);
        check_eq("rst_phase", os_phase, 0);
        check_eq("rst_div", div_cur, 16'd10417);

        // Defaults: int 651, frac 1.
        rst = 1'b0;
        en = 1'b1;
        r = cyc;
        clear_q();
        wait_os(34, 30000, "def_timeout");
        check_eq("def_first", os_t[0] - r, 650);
        for (int i = 1; i <= 15; i++) check_eq("def_int651", os_t[i] - os_t[i-1], 651);
        check_eq("def_int652", os_t[16] - os_t[15], 652);
        check_eq("def_baud_pos", baud_t[0], os_t[15]);
        check_eq("def_baud_ph", ph_t[15], 0);
        check_eq("def_baud_per", baud_t[1] - baud_t[0], 10417);
        check_eq("def_mid0", mid_t[0], os_t[7]);
        check_eq("def_mid1", mid_t[1], os_t[23]);

        // Fraction 4 + 8/16.
        load_div(16'h0048, r);
        check_eq("frac_div", div_cur, 16'h0048);
        check_eq("frac_restart_os", os_tick, 0);
        wait_os(33, 400, "frac_timeout");
        check_eq("frac_first", os_t[0] - r, 3);
        check_eq("frac_i1", os_t[1] - os_t[0], 4);
        check_eq("frac_i2", os_t[2] - os_t[1], 5);
        check_eq("frac_i3", os_t[3] - os_t[2], 4);
        check_eq("frac_i4", os_t[4] - os_t[3], 5);
        check_eq("frac_baud_per", baud_t[1] - baud_t[0], 72);

        // Clamp: int 1 becomes 2.
        load_div(16'h0010, r);
        check_eq("clamp_div", div_cur, 16'h0020);
        wait_os(33, 200, "clamp_timeout");
        check_eq("clamp_first", os_t[0] - r, 1);
        check_eq("clamp_int", os_t[1] - os_t[0], 2);
        check_eq("clamp_baud_per", baud_t[1] - baud_t[0], 32);

        // Resync mid-interval at os_phase 5, divisor 10.
        load_div(16'h00A0, r);
        wait_os(5, 200, "rsy_pre_timeout");
        check_eq("rsy_pre_phase", os_phase, 5);
        repeat (3) step();
        resync = 1'b1;
        step();
        resync = 1'b0;
        r = cyc;
        check_eq("rsy_no_tick", os_tick, 0);
        check_eq("rsy_phase0", os_phase, 0);
        clear_q();
        wait_os(8, 200, "rsy_timeout");
        check_eq("rsy_first", os_t[0] - r, 9);
        check_eq("rsy_int", os_t[1] - os_t[0], 10);
        check_eq("rsy_mid", mid_t[0], os_t[7]);

        // Enable gap of 100 cycles, divisor 4 + 8/16.
        load_div(16'h0048, r);
        wait_os(5, 200, "en_pre_timeout");
        step();
        step();
        en = 1'b0;
        n_before = os_t.size();
        for (int i = 0; i < 100; i++) step();
        t_gap = os_t.size();
        check_eq("en_no_ticks", t_gap, n_before);
        check_eq("en_phase_hold", os_phase, 5);
        en = 1'b1;
        wait_os(17, 400, "en_timeout");
        check_eq("en_shift", os_t[5] - os_t[4], 104);
        check_eq("en_next", os_t[6] - os_t[5], 5);
        check_eq("en_baud_pos", baud_t[0], os_t[15]);
        check_eq("en_baud_shift", baud_t[0] - os_t[0], 167);

        // Reset one cycle before a due baud_tick (due at r+70).
        load_div(16'h0048, r);
        while (cyc < r + 69) step();
        check_eq("rstb_pre_ticks", os_t.size(), 15);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("rstb_os", os_tick, 0);
        check_eq("rstb_baud", baud_tick, 0);
        check_eq("rstb_mid", mid_tick, 0);
        check_eq("rstb_phase", os_phase, 0);
        check_eq("rstb_div", div_cur, 16'd10417);
        check_eq("rstb_no_baud", baud_t.size(), 0);
        check_eq("os1_alive", os1_count > 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/baud_gen_frac.md
Name: baud_gen_frac

Overview:
- Next-generation UART baud generator with a fixed-point fractional divisor and an oversampling tick for the receiver.
- Outputs: os_tick at OVERSAMPLE× baud, baud_tick at 1× baud for the TX, and mid_tick at the bit centre for the RX sampler.
- The divisor is reprogrammable at run time; the RX start-bit detector can realign the phase with resync.
- Sits between the clock domain and uart_tx / uart_rx.

Parameters:
- CLK_FREQ, 100_000_000: system clock in Hz.
- BAUD_RATE, 9600: reset-time baud rate.
- OVERSAMPLE, 16: os_ticks per bit; power of two, 1..64.
- DIV_W, 12: integer divisor width.
- FRAC_W, 4: fractional divisor width.
- DEFAULT_DIV, round(CLK_FREQ*2^FRAC_W/(BAUD_RATE*OVERSAMPLE)): reset divisor, DIV_W+FRAC_W bits. Equals 10417 for the defaults (int 651, frac 1).

Ports:
- clk  in  1: system clock; all logic on rising edge.
- rst  in  1: synchronous reset, active-high.
- en  in  1: count enable.
- div_load  in  1: load div_in into the divisor register.
- div_in  in  DIV_W+FRAC_W: new divisor; upper DIV_W bits = integer part, lower FRAC_W bits = fraction.
- resync  in  1: restart the phase (RX start-bit alignment).
- os_tick  out  1: one-cycle oversample tick.
- baud_tick  out  1: one-cycle bit tick.
- mid_tick  out  1: one-cycle bit-centre tick.
- os_phase  out  clog2(OVERSAMPLE), min 1: oversample index within the current bit.
- div_cur  out  DIV_W+FRAC_W: divisor currently in use.

Behaviour:
- Reset values (all synchronous, on rst):
  - div_cur = DEFAULT_DIV.
  - os_tick = baud_tick = mid_tick = 0.
  - os_phase = 0.
  - Internal cycle counter and fraction accumulator acc = 0.
- Priority: rst > div_load > resync > en.
- Restart: a cycle with rst, div_load or resync high.
  - Clears counter, acc and os_phase.
  - No tick is asserted in a restart cycle.
  - div_load also sets div_cur <= div_in.
  - An integer part < 2 is clamped to 2 on load; div_cur shows the clamped value.
- First os_tick after restart: asserted in cycle T+div_int, where T is the last restart cycle and en is high throughout. The fraction is not applied to this first interval.
- Subsequent intervals:
  - At each os_tick, acc <= (acc + div_frac) mod 2^FRAC_W.
  - The next interval is div_int+1 cycles if that add carried, otherwise div_int cycles.
  - Any 2^FRAC_W consecutive steady-state intervals sum to exactly div_int*2^FRAC_W + div_frac cycles.
- All outputs are registered. Each tick is high for exactly one clk.
- os_phase: increments on each os_tick and wraps OVERSAMPLE-1 -> 0.
- baud_tick: coincides with the os_tick on which os_phase wraps to 0.
- mid_tick: coincides with the os_tick on which os_phase becomes OVERSAMPLE/2.
- OVERSAMPLE==1: os_phase stuck at 0; baud_tick = mid_tick = os_tick.
- en low:
  - Counter, acc and os_phase hold; no ticks.
  - When en returns high, counting resumes mid-interval; there is no restart.
  - A restart while en is low still clears state.
- div_load during counting: the old divisor is abandoned immediately; timing follows the restart rule with the new divisor.
- resync and div_load in the same cycle: treated as a single restart with the new divisor.
- No tick is lost or doubled at the acc wrap boundary.
- Counter width must hold 2^DIV_W without overflow.

Test Plan:
- Defaults:
  - Stimulus: release rst, en=1.
  - Response: first os_tick at cycle 651 after the restart cycle; the next 15 intervals are 651; the 17th is 652.
  - Response: baud_tick period 10417 cycles steady state; mid_tick lands 8 os_ticks after each baud_tick.
- Fraction pattern:
  - Stimulus: div_load with int 4, frac 8.
  - Response: os_tick intervals 4,4,5,4,5,...; baud_tick every 72 cycles; div_cur = 16'h0048.
- Clamp:
  - Stimulus: div_load with int 1, frac 0.
  - Response: div_cur integer = 2; os_tick every 2 cycles; baud_tick every 32 cycles.
- Resync:
  - Stimulus: resync pulsed mid-interval with os_phase=5.
  - Response: no tick that cycle; os_phase=0; next os_tick exactly div_int cycles later; mid_tick 8 os_ticks after that.
- Enable gating:
  - Stimulus: en low for 100 cycles mid-interval.
  - Response: no ticks; the os_tick/baud_tick schedule is shifted by exactly 100 cycles; os_phase is unchanged across the gap.
- Reset and OVERSAMPLE=1:
  - Stimulus: rst asserted one cycle before a due baud_tick.
  - Response: no tick; all outputs and div_cur return to reset values.
  - Stimulus: OVERSAMPLE=1 build.
  - Response: baud_tick, mid_tick and os_tick identical every cycle.
